rice_csr_access_arbiter: RTL and testbench
==========================================

// Module: rice_csr_access_arbiter
// PURPOSE
//  Shares the single rggen CSR bus between two requesters: core pipeline (req 0) and debug module (req 1).
//  Sequences each access as one bus transaction, returns read data and status to the granted requester.
//  Drives the write/read enables that gate the variable-access registers.
//  Debug requests win ties; a burst limit guarantees core progress.
// PARAMETERS
//  ADDRESS_WIDTH   8    CSR byte-address width
//  BUS_WIDTH       32   CSR data width; strobe width BUS_WIDTH/8
//  MAX_DEBUG_BURST 4    consecutive debug grants allowed while core is pending (>=1)
//  TIMEOUT_CYCLES  64   bus-wait limit, used only with RICE_CSR_ARB_TIMEOUT_EN (>=2)
// PORTS
//  i_clk              in   1              clock, all state on rising edge
//  i_rst              in   1              synchronous reset, active-high
//  i_req_valid        in   2              per-requester request valid ([0]=core, [1]=debug)
//  o_req_ready        out  2              request accepted this cycle (one-hot or 0)
//  i_req_access       in   2x2            rggen_access_type per requester (READ/WRITE/POSTED_WRITE)
//  i_req_address      in   2xADDRESS_WIDTH request address
//  i_req_write_data   in   2xBUS_WIDTH    write data
//  i_req_strobe       in   2xBUS_WIDTH/8  byte strobes
//  o_resp_valid       out  2              one-cycle response pulse to owning requester
//  o_resp_read_data   out  BUS_WIDTH      read data, valid with o_resp_valid
//  o_resp_status      out  2              rggen_status (OKAY/EXOKAY/SLAVE_ERROR/DECODE_ERROR)
//  o_csr_valid        out  1              CSR bus request valid
//  o_csr_access       out  2              CSR bus access type
//  o_csr_address      out  ADDRESS_WIDTH  CSR bus address
//  o_csr_write_data   out  BUS_WIDTH      CSR bus write data
//  o_csr_strobe       out  BUS_WIDTH/8    CSR bus strobes
//  i_csr_ready        in   1              CSR bus completion
//  i_csr_status       in   2              CSR bus status, sampled with i_csr_ready
//  i_csr_read_data    in   BUS_WIDTH      CSR bus read data, sampled with i_csr_ready
//  o_write_enable     out  1              write permission to variable-access registers
//  o_read_enable      out  1              read permission to variable-access registers
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; burst counter 0; any in-flight access dropped, no o_resp_valid.
//  - FSM: IDLE -> BUS -> RESP -> IDLE. Min 3 cycles per access; no pipelining.
//  - IDLE: if any i_req_valid, pick winner, assert its o_req_ready combinationally, register its fields, go BUS.
//  - Arbitration: debug wins if valid, unless core valid and burst_cnt==MAX_DEBUG_BURST -> core wins.
//    burst_cnt: +1 on debug grant with core valid; cleared on core grant or when core not valid; saturates.
//  - BUS: o_csr_valid=1, o_csr_* from registers, held stable until i_csr_ready. Capture status/data; go RESP.
//  - RESP: o_resp_valid[owner]=1 exactly one cycle; read data/status held that cycle; go IDLE.
//    Read data returned 0 for write accesses.
//  - Enables (BUS only, else 0): debug owner -> write=read=1. Core owner -> write=1 iff access is
//    WRITE/POSTED_WRITE, read=1 iff READ. Registers thus refuse core accesses of the wrong direction.
//  - Requester valid dropped before ready: no effect. Valid held during BUS/RESP: o_req_ready stays 0.
//  - i_csr_ready outside BUS ignored.
// CONFIGURATION
//  RICE_CSR_ARB_TIMEOUT_EN defined: counter cleared on entering BUS, +1 per BUS cycle; at TIMEOUT_CYCLES
//   without i_csr_ready, drop o_csr_valid, go RESP with status SLAVE_ERROR, read data 0.
//   i_csr_ready in the same cycle as expiry wins (normal completion).
//  Undefined: no counter, BUS waits indefinitely for i_csr_ready.
// STRUCTURE
//  Package rice_csr_arb_pkg: state enum {IDLE,BUS,RESP}, requester index constants CORE=0/DEBUG=1,
//   access-direction helper functions (is_write/is_read on rggen_access_type).
//  Sub-module rice_csr_arb_timer: timeout counter with clear/enable/expired, instantiated only under the macro.
//  Status/access encodings come from rggen_rtl_pkg; no local redefinition.
// TESTING
//  Core READ 0x10, ready after 2 cycles, data 0xDEAD_BEEF -> o_resp_valid=2'b01 with data 0xDEADBEEF, status OKAY.
//  Both valid in same cycle -> debug granted; debug held valid 5 accesses -> 5th grant goes to core (MAX=4).
//  Core READ: o_read_enable=1, o_write_enable=0 in BUS. Core WRITE: write=1, read=0. Debug: both 1.
//  i_rst asserted during BUS -> next cycle IDLE, o_csr_valid=0, no response pulse.
//  TIMEOUT_EN, TIMEOUT_CYCLES=8, no ready -> o_csr_valid low after 8 BUS cycles, status SLAVE_ERROR, data 0.
//  Back-to-back core WRITEs with strobe 4'b0011 -> bus fields stable across wait states, one resp each.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Access-type and status encodings of the rggen CSR bus, shared by every
// block that speaks to the register file.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_READ         = 2'b10,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

endpackage

// File: rtl/rice_csr_arb_pkg.sv
// Shared types for the CSR access arbiter: FSM states, requester indices and
// access-direction helpers.
package rice_csr_arb_pkg;
  import rggen_rtl_pkg::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int CORE  = 0;
  localparam int DEBUG = 1;

  function automatic logic is_write(input rggen_access access);
    return (access == RGGEN_WRITE) || (access == RGGEN_POSTED_WRITE);
  endfunction

  function automatic logic is_read(input rggen_access access);
    return access == RGGEN_READ;
  endfunction

endpackage

// File: rtl/rice_csr_arb_if.sv
// The rggen CSR bus as seen by the arbiter (master) and the register file
// (slave).
interface rice_csr_arb_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                   valid;
  logic [1:0]             access;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]   write_data;
  logic [BUS_WIDTH/8-1:0] strobe;
  logic                   ready;
  logic [1:0]             status;
  logic [BUS_WIDTH-1:0]   read_data;

  modport master (
    output valid, access, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, access, address, write_data, strobe,
    output ready, status, read_data
  );
endinterface

// File: rtl/rice_csr_arb_timer.sv
// Bus-wait watchdog: counts cycles while enabled and flags expiry on the
// TIMEOUT_CYCLES-th enabled cycle.
module rice_csr_arb_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_count;

  assign o_expired = i_enable && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/rice_csr_access_arbiter.sv
// Two-requester arbiter (core / debug) for the single rggen CSR bus.
// Optional bus-wait timeout is built when RICE_CSR_ARB_TIMEOUT_EN is defined.
module rice_csr_access_arbiter
  import rggen_rtl_pkg::*;
  import rice_csr_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 8,
  parameter int BUS_WIDTH       = 32,
  parameter int MAX_DEBUG_BURST = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [1:0]                        i_req_valid,
  output logic [1:0]                        o_req_ready,
  input  logic [1:0][1:0]                   i_req_access,
  input  logic [1:0][ADDRESS_WIDTH-1:0]     i_req_address,
  input  logic [1:0][BUS_WIDTH-1:0]         i_req_write_data,
  input  logic [1:0][BUS_WIDTH/8-1:0]       i_req_strobe,
  output logic [1:0]                        o_resp_valid,
  output logic [BUS_WIDTH-1:0]              o_resp_read_data,
  output logic [1:0]                        o_resp_status,
  rice_csr_arb_if.master                    csr_if,
  output logic                              o_write_enable,
  output logic                              o_read_enable
);
  localparam int BURST_W = $clog2(MAX_DEBUG_BURST + 1);

  if (MAX_DEBUG_BURST < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("rice_csr_access_arbiter: MAX_DEBUG_BURST must be >=1 and TIMEOUT_CYCLES >=2");
  end

  arb_state_e               r_state;
  arb_state_e               w_state_next;
  logic                     r_owner;
  rggen_access              r_access;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic [BUS_WIDTH-1:0]     r_write_data;
  logic [BUS_WIDTH/8-1:0]   r_strobe;
  logic [BUS_WIDTH-1:0]     r_read_data;
  rggen_status              r_status;
  logic [BURST_W-1:0]       r_burst_cnt;

  logic w_idle;
  logic w_bus;
  logic w_resp;
  logic w_burst_full;
  logic w_debug_wins;
  logic w_grant;
  logic w_grant_idx;
  logic w_bus_done;
  logic w_bus_abort;
  logic w_timeout;

  assign w_idle = (r_state == IDLE);
  assign w_bus  = (r_state == BUS);
  assign w_resp = (r_state == RESP);

  // Debug has priority unless it has already starved a waiting core for a full burst.
  assign w_burst_full = (r_burst_cnt == BURST_W'(MAX_DEBUG_BURST));
  assign w_debug_wins = i_req_valid[DEBUG] && !(i_req_valid[CORE] && w_burst_full);
  assign w_grant      = w_idle && (|i_req_valid);
  assign w_grant_idx  = w_debug_wins;

  assign w_bus_done  = w_bus && csr_if.ready;
  assign w_bus_abort = w_bus && w_timeout && !csr_if.ready;

`ifdef RICE_CSR_ARB_TIMEOUT_EN
  rice_csr_arb_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_grant),
    .i_enable  (w_bus),
    .o_expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next   = r_state;
    o_req_ready    = 2'b00;
    o_write_enable = 1'b0;
    o_read_enable  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          o_req_ready  = w_grant_idx ? 2'b10 : 2'b01;
          w_state_next = BUS;
        end
      end
      BUS: begin
        if (r_owner) begin
          o_write_enable = 1'b1;
          o_read_enable  = 1'b1;
        end else begin
          o_write_enable = is_write(r_access);
          o_read_enable  = is_read(r_access);
        end
        if (w_bus_done || w_bus_abort) begin
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the small request/response holding registers are reset too, so no stale field ever reaches the bus.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner      <= 1'b0;
      r_access     <= RGGEN_READ;
      r_address    <= '0;
      r_write_data <= '0;
      r_strobe     <= '0;
      r_read_data  <= '0;
      r_status     <= RGGEN_OKAY;
    end else if (w_grant) begin
      r_owner      <= w_grant_idx;
      r_access     <= rggen_access'(i_req_access[w_grant_idx]);
      r_address    <= i_req_address[w_grant_idx];
      r_write_data <= i_req_write_data[w_grant_idx];
      r_strobe     <= i_req_strobe[w_grant_idx];
    end else if (w_bus_done) begin
      r_status    <= rggen_status'(csr_if.status);
      r_read_data <= is_read(r_access) ? csr_if.read_data : '0;
    end else if (w_bus_abort) begin
      r_status    <= RGGEN_SLAVE_ERROR;
      r_read_data <= '0;
    end
  end

  // Burst count only matters while the core is actually waiting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_burst_cnt <= '0;
    end else if (!i_req_valid[CORE]) begin
      r_burst_cnt <= '0;
    end else if (w_grant && !w_grant_idx) begin
      r_burst_cnt <= '0;
    end else if (w_grant && w_grant_idx && !w_burst_full) begin
      r_burst_cnt <= r_burst_cnt + 1'b1;
    end
  end

  assign csr_if.valid      = w_bus;
  assign csr_if.access     = w_bus ? r_access     : 2'b00;
  assign csr_if.address    = w_bus ? r_address    : '0;
  assign csr_if.write_data = w_bus ? r_write_data : '0;
  assign csr_if.strobe     = w_bus ? r_strobe     : '0;

  assign o_resp_valid     = w_resp ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign o_resp_read_data = w_resp ? r_read_data : '0;
  assign o_resp_status    = w_resp ? r_status    : RGGEN_OKAY;

endmodule

// File: tb/tb_rice_csr_access_arbiter.sv
// Directed bench for rice_csr_access_arbiter: scoreboard of expected responses,
// immediate-assertion checks, timeout case when RICE_CSR_ARB_TIMEOUT_EN is defined.
module tb_rice_csr_access_arbiter;
  import rggen_rtl_pkg::*;

  localparam int AW  = 8;
  localparam int BW  = 32;
  localparam int MAX = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][1:0]        req_access;
  logic [1:0][AW-1:0]     req_address;
  logic [1:0][BW-1:0]     req_write_data;
  logic [1:0][BW/8-1:0]   req_strobe;
  logic [1:0]             resp_valid;
  logic [BW-1:0]          resp_read_data;
  logic [1:0]             resp_status;
  logic                   wen;
  logic                   ren;

  rice_csr_arb_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) csr_if ();

  rice_csr_access_arbiter #(
    .ADDRESS_WIDTH   (AW),
    .BUS_WIDTH       (BW),
    .MAX_DEBUG_BURST (MAX),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_access     (req_access),
    .i_req_address    (req_address),
    .i_req_write_data (req_write_data),
    .i_req_strobe     (req_strobe),
    .o_resp_valid     (resp_valid),
    .o_resp_read_data (resp_read_data),
    .o_resp_status    (resp_status),
    .csr_if           (csr_if),
    .o_write_enable   (wen),
    .o_read_enable    (ren)
  );

  typedef struct {
    logic [1:0]    valid;
    logic [BW-1:0] data;
    logic [1:0]    status;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input rggen_access acc, input logic [AW-1:0] addr,
                         input logic [BW-1:0] wd, input logic [BW/8-1:0] st);
    req_access[idx]     = acc;
    req_address[idx]    = addr;
    req_write_data[idx] = wd;
    req_strobe[idx]     = st;
    req_valid[idx]      = 1'b1;
  endtask

  // Entered at an IDLE negedge with the request(s) already driven; returns at the next IDLE negedge.
  task automatic serve(input string tag, input int owner, input rggen_access acc,
                       input logic [AW-1:0] addr, input logic [BW-1:0] wd, input logic [BW/8-1:0] st,
                       input int waits, input logic [BW-1:0] rd, input rggen_status status,
                       input bit hold);
    exp_t e;
    logic [1:0] exp_en;
    exp_en = (owner == 1) ? 2'b11 : ((acc == RGGEN_READ) ? 2'b01 : 2'b10);
    #1;
    check({tag, ".ready"}, req_ready, (owner == 1) ? 2'b10 : 2'b01);
    e.valid  = (owner == 1) ? 2'b10 : 2'b01;
    e.data   = (acc == RGGEN_READ) ? rd : '0;
    e.status = status;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) req_valid[owner] = 1'b0;
    for (int w = 0; w <= waits; w++) begin
      check({tag, ".csr_valid"}, csr_if.valid, 1'b1);
      check({tag, ".csr_access"}, csr_if.access, acc);
      check({tag, ".csr_addr"}, csr_if.address, addr);
      check({tag, ".csr_wdata"}, csr_if.write_data, wd);
      check({tag, ".csr_strobe"}, csr_if.strobe, st);
      check({tag, ".enables"}, {wen, ren}, exp_en);
      check({tag, ".ready_bus"}, req_ready, 2'b00);
      check({tag, ".resp_bus"}, resp_valid, 2'b00);
      if (w == waits) begin
        csr_if.ready     = 1'b1;
        csr_if.read_data = rd;
        csr_if.status    = status;
      end else begin
        csr_if.ready     = 1'b0;
        csr_if.read_data = 32'hBAD0_0000 | BW'(w);
        csr_if.status    = RGGEN_DECODE_ERROR;
      end
      @(negedge clk);
    end
    csr_if.ready = 1'b0;
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, ".resp_valid"}, resp_valid, e.valid);
    check({tag, ".resp_data"}, resp_read_data, e.data);
    check({tag, ".resp_status"}, resp_status, e.status);
    check({tag, ".csr_idle"}, csr_if.valid, 1'b0);
    check({tag, ".en_resp"}, {wen, ren}, 2'b00);
    check({tag, ".ready_resp"}, req_ready, 2'b00);
    @(negedge clk);
    check({tag, ".resp_once"}, resp_valid, 2'b00);
  endtask

  initial begin
    rst              = 1'b1;
    req_valid        = 2'b00;
    req_access       = '0;
    req_address      = '0;
    req_write_data   = '0;
    req_strobe       = '0;
    csr_if.ready     = 1'b0;
    csr_if.status    = RGGEN_OKAY;
    csr_if.read_data = '0;
    repeat (3) @(negedge clk);

    check("rst.req_ready", req_ready, 2'b00);
    check("rst.csr_valid", csr_if.valid, 1'b0);
    check("rst.resp_valid", resp_valid, 2'b00);
    check("rst.enables", {wen, ren}, 2'b00);
    check("rst.csr_addr", csr_if.address, '0);
    rst = 1'b0;
    @(negedge clk);

    // Stray bus completion while idle must do nothing.
    csr_if.ready     = 1'b1;
    csr_if.read_data = 32'h5555_5555;
    @(negedge clk);
    csr_if.ready = 1'b0;
    check("stray.csr_valid", csr_if.valid, 1'b0);
    check("stray.resp", resp_valid, 2'b00);
    @(negedge clk);
    check("stray.resp2", resp_valid, 2'b00);

    set_req(0, RGGEN_READ, 8'h10, 32'h0, 4'hF);
    serve("core_rd", 0, RGGEN_READ, 8'h10, 32'h0, 4'hF, 2, 32'hDEAD_BEEF, RGGEN_OKAY, 1'b0);

    set_req(0, RGGEN_WRITE, 8'h20, 32'h1234_5678, 4'b0011);
    serve("core_wr0", 0, RGGEN_WRITE, 8'h20, 32'h1234_5678, 4'b0011, 3, 32'hFFFF_FFFF, RGGEN_OKAY, 1'b0);
    set_req(0, RGGEN_WRITE, 8'h24, 32'hCAFE_0011, 4'b0011);
    serve("core_wr1", 0, RGGEN_WRITE, 8'h24, 32'hCAFE_0011, 4'b0011, 1, 32'h0F0F_0F0F, RGGEN_OKAY, 1'b0);
    set_req(0, RGGEN_POSTED_WRITE, 8'h28, 32'hA5A5_0000, 4'b1100);
    serve("core_pw", 0, RGGEN_POSTED_WRITE, 8'h28, 32'hA5A5_0000, 4'b1100, 0, 32'h1111_1111,
          RGGEN_SLAVE_ERROR, 1'b0);

    // Both valid: debug takes MAX grants in a row, then the waiting core gets one.
    set_req(0, RGGEN_READ, 8'h30, 32'h0, 4'hF);
    set_req(1, RGGEN_READ, 8'h40, 32'h0, 4'hF);
    for (int i = 0; i < MAX; i++) begin
      serve($sformatf("dbg%0d", i), 1, RGGEN_READ, 8'h40, 32'h0, 4'hF, i % 2, 32'h1000_0000 + BW'(i),
            (i == 2) ? RGGEN_DECODE_ERROR : RGGEN_EXOKAY, 1'b1);
    end
    serve("core_after_burst", 0, RGGEN_READ, 8'h30, 32'h0, 4'hF, 1, 32'h0000_C0DE, RGGEN_OKAY, 1'b0);
    serve("dbg_last", 1, RGGEN_READ, 8'h40, 32'h0, 4'hF, 0, 32'h2222_3333, RGGEN_OKAY, 1'b0);

    set_req(1, RGGEN_WRITE, 8'h44, 32'h7777_8888, 4'hF);
    serve("dbg_wr", 1, RGGEN_WRITE, 8'h44, 32'h7777_8888, 4'hF, 1, 32'h9999_9999, RGGEN_OKAY, 1'b0);

    // Reset while the bus is busy drops the access without a response.
    set_req(0, RGGEN_READ, 8'h50, 32'h0, 4'hF);
    @(negedge clk);
    req_valid = 2'b00;
    check("rstbus.csr_valid", csr_if.valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstbus.csr_drop", csr_if.valid, 1'b0);
    check("rstbus.resp", resp_valid, 2'b00);
    check("rstbus.enables", {wen, ren}, 2'b00);
    @(negedge clk);
    check("rstbus.resp2", resp_valid, 2'b00);
    check("rstbus.csr_idle", csr_if.valid, 1'b0);

`ifdef RICE_CSR_ARB_TIMEOUT_EN
    set_req(0, RGGEN_READ, 8'h60, 32'h0, 4'hF);
    #1;
    check("tmo.ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid[0]     = 1'b0;
    csr_if.read_data = 32'hFFFF_FFFF;
    for (int c = 0; c < TMO; c++) begin
      check($sformatf("tmo.bus%0d", c), csr_if.valid, 1'b1);
      @(negedge clk);
    end
    check("tmo.csr_drop", csr_if.valid, 1'b0);
    check("tmo.resp_valid", resp_valid, 2'b01);
    check("tmo.resp_status", resp_status, RGGEN_SLAVE_ERROR);
    check("tmo.resp_data", resp_read_data, 32'h0);
    @(negedge clk);
    check("tmo.resp_once", resp_valid, 2'b00);
`endif

    check("sb.drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
